// File: rtl/ddr_instr_packer_if.sv
// Host-side bus of the DDR instruction packer: command stream in, IMEM write port out.
// Shared macro defaults live here so every file of the bundle sees the same encoding.
`ifndef IMEM_ADDR_WIDTH
`define IMEM_ADDR_WIDTH 10
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 64
`endif
`ifndef DDR_OFFSET
`define DDR_OFFSET 63
`endif
`ifndef DDR_CODE_OFFSET
`define DDR_CODE_OFFSET 13
`endif
`ifndef NOP
`define NOP 3'b111
`endif

// Handshakes: a transfer happens on any clock edge where valid and ready are both
// high (cmd_valid/cmd_ready, imem_wr_en/imem_wr_ready); the sender holds its
// payload stable while valid is high and ready is low.
interface ddr_instr_packer_if #(
    parameter int ADDR_W = `IMEM_ADDR_WIDTH,
    parameter int SLOT_W = 16
);
    logic                    start;
    logic [ADDR_W-1:0]       start_addr;
    logic [SLOT_W-1:0]       cmd;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    flush;
    logic                    imem_wr_en;
    logic                    imem_wr_ready;
    logic [ADDR_W-1:0]       imem_wr_addr;
    logic [`INSTR_WIDTH-1:0] imem_wr_data;
    logic [ADDR_W:0]         words_written;
    logic                    done;
    logic                    overflow;
    logic [1:0]              fsm_state;

    modport master (
        output start, start_addr, cmd, cmd_valid, flush, imem_wr_ready,
        input  cmd_ready, imem_wr_en, imem_wr_addr, imem_wr_data,
        input  words_written, done, overflow, fsm_state
    );

    modport slave (
        input  start, start_addr, cmd, cmd_valid, flush, imem_wr_ready,
        output cmd_ready, imem_wr_en, imem_wr_addr, imem_wr_data,
        output words_written, done, overflow, fsm_state
    );
endinterface

// File: rtl/ddr_instr_packer.sv
// Packs four 16-bit DDR commands into one instruction word (DDR flag set) and
// writes the words to consecutive IMEM addresses.
`ifndef IMEM_ADDR_WIDTH
`define IMEM_ADDR_WIDTH 10
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 64
`endif
`ifndef DDR_OFFSET
`define DDR_OFFSET 63
`endif
`ifndef DDR_CODE_OFFSET
`define DDR_CODE_OFFSET 13
`endif
`ifndef NOP
`define NOP 3'b111
`endif

module ddr_instr_packer #(
    parameter int                 ADDR_W   = `IMEM_ADDR_WIDTH,
    parameter int                 SLOT_W   = 16,
    parameter logic [SLOT_W-1:0]  NOP_SLOT = SLOT_W'(`NOP) << `DDR_CODE_OFFSET
) (
    input logic              clk,
    input logic              rst,
    ddr_instr_packer_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] EMIT = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [1:0]              state;
    logic [SLOT_W-1:0]       slots [4];
    logic [2:0]              slot_idx;
    logic [2:0]              idx_after;
    logic                    pend_flush;
    logic                    accept;
    logic [ADDR_W-1:0]       wr_addr;
    logic [ADDR_W:0]         words_cnt;
    logic                    done_q;
    logic                    overflow_q;
    logic [`INSTR_WIDTH-1:0] packed_word;

    assign accept    = (state == FILL) && bus.cmd_valid;
    assign idx_after = slot_idx + {2'b00, accept};

    // Slot 0 is the first command issued and lands in the low bits.
    always_comb begin
        packed_word = {slots[3], slots[2], slots[1], slots[0]};
        packed_word[`DDR_OFFSET] = 1'b1;
    end

    assign bus.cmd_ready     = (state == FILL);
    assign bus.imem_wr_en    = (state == EMIT);
    assign bus.imem_wr_data  = (state == EMIT) ? packed_word : '0;
    assign bus.imem_wr_addr  = wr_addr;
    assign bus.words_written = words_cnt;
    assign bus.done          = done_q;
    assign bus.overflow      = overflow_q;
    assign bus.fsm_state     = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            slot_idx   <= '0;
            pend_flush <= 1'b0;
            wr_addr    <= '0;
            words_cnt  <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            for (int i = 0; i < 4; i++) slots[i] <= NOP_SLOT;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        wr_addr    <= bus.start_addr;
                        words_cnt  <= '0;
                        overflow_q <= 1'b0;
                        slot_idx   <= '0;
                        pend_flush <= 1'b0;
                        for (int i = 0; i < 4; i++) slots[i] <= NOP_SLOT;
                        state      <= FILL;
                    end
                end

                FILL: begin
                    if (accept) begin
                        slots[slot_idx[1:0]] <= bus.cmd;
                        slot_idx             <= idx_after;
                    end
                    // A completing accept wins; its flush is carried into EMIT.
                    if (accept && slot_idx == 3'd3) begin
                        state      <= EMIT;
                        pend_flush <= bus.flush;
                    end else if (bus.flush) begin
                        if (idx_after != 3'd0) begin
                            state      <= EMIT;
                            pend_flush <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end

                EMIT: begin
                    if (bus.flush) pend_flush <= 1'b1;
                    if (bus.imem_wr_ready) begin
                        words_cnt <= words_cnt + 1'b1;
                        slot_idx  <= '0;
                        for (int i = 0; i < 4; i++) slots[i] <= NOP_SLOT;
                        // The last IMEM address ends the burst without wrapping.
                        if (wr_addr == LAST_ADDR) begin
                            overflow_q <= 1'b1;
                            done_q     <= 1'b1;
                            pend_flush <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            wr_addr <= wr_addr + 1'b1;
                            if (pend_flush || bus.flush) begin
                                done_q     <= 1'b1;
                                pend_flush <= 1'b0;
                                state      <= IDLE;
                            end else begin
                                state <= FILL;
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule
